// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// mem_bus_arbiter_pkg : shared bus mode codes, arbiter state and owner codes
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [2:0] BUS_NULL = 3'd0;
  localparam logic [2:0] BUS_QUAR = 3'd1;
  localparam logic [2:0] BUS_HALF = 3'd2;
  localparam logic [2:0] BUS_FULL = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_pick.sv
// ============================================================================
// mem_arb_pick : winner select between fetch and load/store requests
// Build option MEM_ARB_RR_EN selects round-robin instead of D-over-I priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_i,
  output logic pick_i_o,
  output logic pick_d_o
);

`ifdef MEM_ARB_RR_EN
  // On contention the side that was not granted last wins.
  always_comb begin
    pick_i_o = 1'b0;
    pick_d_o = 1'b0;
    if (i_req_i && d_req_i) begin
      pick_d_o = (last_i == ARB_OWNER_I);
      pick_i_o = (last_i == ARB_OWNER_D);
    end else begin
      pick_i_o = i_req_i;
      pick_d_o = d_req_i;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = last_i;

  always_comb begin
    pick_d_o = d_req_i;
    pick_i_o = i_req_i & ~d_req_i;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : shares one memory bus port between fetch and load/store
// Build option MEM_ARB_RR_EN enables round-robin arbitration.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_wr,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [2:0]      d_mode,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            bus_valid,
  output logic            bus_wr,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [2:0]      bus_mode,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata
);

  arb_state_t      state_q;
  logic            owner_q;
  logic            valid_q;
  logic            wr_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      mode_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            i_rvalid_q;
  logic            d_rvalid_q;

  logic w_last;
  logic w_pick_i;
  logic w_pick_d;
  logic w_idle;
  logic w_timeout;

  assign w_idle = (state_q == ARB_IDLE);
  assign i_gnt  = w_idle & w_pick_i;
  assign d_gnt  = w_idle & w_pick_d;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ARB_OWNER_I;
    end else if (i_gnt || d_gnt) begin
      last_q <= d_gnt ? ARB_OWNER_D : ARB_OWNER_I;
    end
  end
  assign w_last = last_q;
`else
  assign w_last = ARB_OWNER_I;
`endif

  mem_arb_pick u_pick (
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .last_i   (w_last),
    .pick_i_o (w_pick_i),
    .pick_d_o (w_pick_d)
  );

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int              CW        = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0]   C_TO_LAST = CW'(TIMEOUT - 1);
      logic [CW-1:0]              cnt_q;

      // Expires on the TIMEOUT-th BUSY cycle without bus_ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (state_q == ARB_BUSY && !bus_ready && cnt_q != C_TO_LAST) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          cnt_q <= '0;
        end
      end
      assign w_timeout = (state_q == ARB_BUSY) && (cnt_q == C_TO_LAST);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= ARB_OWNER_I;
      valid_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= BUS_NULL;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (w_pick_d || w_pick_i) begin
            owner_q <= w_pick_d ? ARB_OWNER_D : ARB_OWNER_I;
            valid_q <= 1'b1;
            wr_q    <= w_pick_d & d_wr;
            addr_q  <= w_pick_d ? d_addr  : i_addr;
            wdata_q <= w_pick_d ? d_wdata : '0;
            mode_q  <= w_pick_d ? d_mode  : BUS_FULL;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // bus_ready takes precedence over a coincident timeout.
          if (bus_ready || w_timeout) begin
            rdata_q    <= (bus_ready && !wr_q) ? bus_rdata : '0;
            err_q      <= ~bus_ready;
            valid_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mode_q     <= BUS_NULL;
            i_rvalid_q <= (owner_q == ARB_OWNER_I);
            d_rvalid_q <= (owner_q == ARB_OWNER_D);
            state_q    <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          i_rvalid_q <= 1'b0;
          d_rvalid_q <= 1'b0;
          state_q    <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus_valid = valid_q;
  assign bus_wr    = wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_mode  = mode_q;

  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = rdata_q;
  assign i_err     = err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = rdata_q;
  assign d_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;
  logic            i_err;
  logic            d_req;
  logic            d_wr;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [2:0]      d_mode;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;
  logic            bus_valid;
  logic            bus_wr;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [2:0]      bus_mode;
  logic            bus_ready;
  logic [XLEN-1:0] bus_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mode(d_mode), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err),
    .bus_valid(bus_valid), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_mode(bus_mode), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  logic exp_d [4];
  logic win_d;
  int   busy;
  logic got;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; d_mode = BUS_NULL; bus_ready = 1'b0; bus_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_mode", {29'd0, bus_mode}, {29'd0, BUS_NULL});
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // I-only fetch, bus_ready on the third BUSY cycle
    i_req = 1'b1; i_addr = 32'h0000_1000;
    #1;
    chk("fetch_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("fetch_d_gnt", {31'd0, d_gnt}, 32'd0);
    tick();
    i_req = 1'b0;
    chk("fetch_bus_valid", {31'd0, bus_valid}, 32'd1);
    chk("fetch_bus_mode", {29'd0, bus_mode}, {29'd0, BUS_FULL});
    chk("fetch_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("fetch_bus_addr", bus_addr, 32'h0000_1000);
    tick(); tick();
    bus_ready = 1'b1; bus_rdata = 32'h0051_3093;
    chk("fetch_no_early_rvalid", {31'd0, i_rvalid}, 32'd0);
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    chk("fetch_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fetch_i_rdata", i_rdata, 32'h0051_3093);
    chk("fetch_i_err", {31'd0, i_err}, 32'd0);
    chk("fetch_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("fetch_resp_bus_valid", {31'd0, bus_valid}, 32'd0);
    tick();
    chk("fetch_rvalid_pulse", {31'd0, i_rvalid}, 32'd0);

    // Contention: D load wins, I granted one cycle after d_rvalid
    i_req = 1'b1; i_addr = 32'h0000_3000;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_2004; d_mode = BUS_HALF; d_wdata = '0;
    #1;
    chk("cont_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("cont_i_gnt", {31'd0, i_gnt}, 32'd0);
    tick();
    d_req = 1'b0;
    chk("cont_bus_addr", bus_addr, 32'h0000_2004);
    chk("cont_bus_mode", {29'd0, bus_mode}, {29'd0, BUS_HALF});
    chk("cont_busy_i_gnt", {31'd0, i_gnt}, 32'd0);
    bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    chk("cont_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("cont_d_rdata", d_rdata, 32'h1234_5678);
    chk("cont_resp_i_gnt", {31'd0, i_gnt}, 32'd0);
    tick();
    chk("cont_i_gnt_after", {31'd0, i_gnt}, 32'd1);
    tick();
    i_req = 1'b0;
    chk("cont_i_bus_addr", bus_addr, 32'h0000_3000);
    bus_ready = 1'b1; bus_rdata = 32'h0000_A5A5;
    tick();
    bus_ready = 1'b0;
    chk("cont_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("cont_i_rdata", i_rdata, 32'h0000_A5A5);
    tick();

    // Repeated contention: D,I,D,I with round-robin, D always otherwise
    i_req = 1'b1; i_addr = 32'h0000_5000;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_6000; d_mode = BUS_FULL;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d[k]});
      chk("rr_i_gnt", {31'd0, i_gnt}, {31'd0, ~exp_d[k]});
      win_d = d_gnt;
      tick();
      if (win_d) d_req = 1'b0; else i_req = 1'b0;
      bus_ready = 1'b1; bus_rdata = 32'h0BAD_0000 + k;
      tick();
      bus_ready = 1'b0;
      chk("rr_rvalid", {31'd0, (win_d ? d_rvalid : i_rvalid)}, 32'd1);
      if (win_d) d_req = 1'b1; else i_req = 1'b1;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Store with bus_ready held low: timeout after 4 BUSY cycles
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_4000; d_wdata = 32'hDEAD_BEEF; d_mode = BUS_QUAR;
    #1;
    chk("to_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    chk("to_bus_wr", {31'd0, bus_wr}, 32'd1);
    chk("to_bus_mode", {29'd0, bus_mode}, {29'd0, BUS_QUAR});
    d_addr = 32'hFFFF_FFF0; d_wdata = 32'h0;
    busy = 0; got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (d_rvalid) begin
        got = 1'b1;
      end else begin
        if (bus_valid) begin
          busy++;
          chk("to_addr_hold", bus_addr, 32'h0000_4000);
          chk("to_wdata_hold", bus_wdata, 32'hDEAD_BEEF);
        end
        tick();
      end
    end
    chk("to_rvalid_seen", {31'd0, got}, 32'd1);
    chk("to_busy_cycles", busy, 32'd4);
    chk("to_d_err", {31'd0, d_err}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    tick();

    // Store with bus_ready on the 4th BUSY cycle: ready beats timeout
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_4400; d_wdata = 32'h0000_1111; d_mode = BUS_QUAR;
    tick();
    d_req = 1'b0;
    busy = 0; got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (d_rvalid) begin
        got = 1'b1;
      end else begin
        if (bus_valid) begin
          busy++;
          if (busy == 4) begin
            bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
          end
        end
        tick();
        bus_ready = 1'b0; bus_rdata = '0;
      end
    end
    chk("rdy4_rvalid_seen", {31'd0, got}, 32'd1);
    chk("rdy4_busy_cycles", busy, 32'd4);
    chk("rdy4_d_err", {31'd0, d_err}, 32'd0);
    chk("rdy4_d_rdata", d_rdata, 32'd0);
    tick();

    // Reset asserted mid-BUSY
    i_req = 1'b1; i_addr = 32'h0000_7000;
    tick();
    i_req = 1'b0;
    chk("mid_bus_valid", {31'd0, bus_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_drop", {31'd0, bus_valid}, 32'd0);
    chk("mid_async_addr", bus_addr, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("mid_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      tick();
    end
    i_req = 1'b1; i_addr = 32'h0000_8000;
    #1;
    chk("post_i_gnt", {31'd0, i_gnt}, 32'd1);
    tick();
    i_req = 1'b0;
    chk("post_bus_addr", bus_addr, 32'h0000_8000);
    bus_ready = 1'b1; bus_rdata = 32'h0000_0077;
    tick();
    bus_ready = 1'b0;
    chk("post_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("post_i_rdata", i_rdata, 32'h0000_0077);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus port between the instruction fetch unit (I side) and the load/store path (D side).
- The D side is driven by the decode outputs mem_load, mem_wr and mem_opt, with data aligned by save_sext and load_sext.
- Grants one requester, holds its address, data and mode in registers, runs one bus transaction, then returns read data or an error to the owner.
- One outstanding transaction in total.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 255, maximum bus wait in cycles. 0 disables the timeout. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_gnt.
- i_addr  in  XLEN  fetch address.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  one-cycle pulse: fetch response valid.
- i_rdata  out  XLEN  fetch read data.
- i_err  out  1  fetch timed out; qualified by i_rvalid.
- d_req  in  1  load/store request; held high until d_gnt.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data, already lane-shifted by save_sext.
- d_mode  in  3  BUS_QUAR, BUS_HALF or BUS_FULL.
- d_gnt  out  1  load/store request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load/store response valid (stores too).
- d_rdata  out  XLEN  raw load data, for load_sext.
- d_err  out  1  load/store timed out; qualified by d_rvalid.
- bus_valid  out  1  bus transaction active.
- bus_wr  out  1  write strobe.
- bus_addr  out  XLEN  bus address.
- bus_wdata  out  XLEN  bus write data.
- bus_mode  out  3  bus access size.
- bus_ready  in  1  slave completes the transaction this cycle.
- bus_rdata  in  XLEN  slave read data; valid when bus_ready.

Behaviour:
- Reset values:
  - state = IDLE; owner = I; last-grant pointer = I.
  - All bus_* outputs 0 (bus_mode = BUS_NULL).
  - rvalid/err/rdata on both sides = 0; timeout counter = 0.
  - Reset asserted mid-transaction drops bus_valid immediately (asynchronous). No response is issued for the aborted transaction.
- State IDLE:
  - gnt is combinational from req and is asserted only in IDLE.
  - Fixed priority: D wins over I when both request.
  - On the granting edge, the arbiter captures owner, address, wdata, mode and wr. The I side is captured as mode = BUS_FULL, wr = 0, wdata = 0.
  - Then moves to BUSY.
  - No req: stay in IDLE, bus outputs hold 0.
- State BUSY:
  - bus_valid = 1; the captured fields are driven from registers and stay stable for the whole of BUSY.
  - bus_ready = 1 sampled: capture bus_rdata (0 for writes), move to RESP.
  - Timeout counter increments each BUSY cycle without bus_ready.
  - Counter reaches TIMEOUT: move to RESP with err = 1 and rdata = 0.
  - bus_ready arriving in the same cycle as the timeout: bus_ready wins, err = 0.
- State RESP:
  - The owner's rvalid = 1 for exactly one cycle, with rdata and err registered.
  - bus_valid = 0 and bus_mode = BUS_NULL; counter is cleared.
  - Next state is IDLE.
- Latency:
  - Grant at cycle T; bus_valid from T+1.
  - bus_ready at T+k gives rvalid at T+k+1.
  - Minimum is 2 cycles from grant to rvalid; the next grant is possible at T+k+2.
- Requesters must not raise req again before receiving their rvalid. The arbiter ignores req from the current owner while in BUSY/RESP.
- d_mode = BUS_NULL with d_req is granted and forwarded unchanged. The slave defines the result.
- TIMEOUT = 0: the counter is removed and BUSY waits indefinitely.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin between the two sides. When both request, grant the side that was not granted last. The pointer updates on every grant and resets to I, so D wins the first contention.
- Undefined: fixed D-over-I priority, and the pointer register is not built.

Decomposition:
- Shared package additions (coredefs.sv):
  - arb_state_t enum: ARB_IDLE, ARB_BUSY, ARB_RESP.
  - ARB_OWNER_I and ARB_OWNER_D constants.
  - The existing BUS_* mode codes and XLEN remain the width sources.
- Sub-module mem_arb_pick: combinational winner select from i_req, d_req and the pointer. Holds the MEM_ARB_RR_EN variants, so the main FSM is identical in both builds.

Test Plan:
- I-only fetch: i_req at T with addr 0x0000_1000; bus_ready at T+3 with rdata 0x0051_3093. Required: i_gnt at T, bus_mode = BUS_FULL, bus_wr = 0, i_rvalid at T+4 with i_rdata 0x0051_3093, i_err = 0.
- Simultaneous i_req and d_req (load, addr 0x0000_2004, mode BUS_HALF), macro off. Required: d_gnt first and bus_addr 0x0000_2004. i_req is held, and i_gnt follows exactly one cycle after d_rvalid.
- Same contention repeated 4 times, MEM_ARB_RR_EN defined. Required grant order D, I, D, I.
- Store with d_wdata 0xDEAD_BEEF, mode BUS_QUAR, bus_ready held low. Required with TIMEOUT = 4: bus_valid for 4 cycles, then d_rvalid with d_err = 1, d_rdata = 0. A separate run with bus_ready at the 4th cycle must give d_err = 0.
- Changing d_addr/d_wdata while in BUSY must not alter bus_addr/bus_wdata.
- rst_n low mid-BUSY. Required: bus_valid = 0 asynchronously, no rvalid pulse on either side, and a new i_req after reset is granted normally.
